// File: rtl/vga_pkg.sv
// Display timing constants and shared types for the VGA pixel path.
// Latency: n/a (package).
// Backpressure: n/a (package).
package vga_pkg;

    // 640x480@60 timing: active, front porch, sync, back porch, total
    localparam int HA = 640;
    localparam int HF = 16;
    localparam int HS = 96;
    localparam int HB = 48;
    localparam int HT = 800;
    localparam int VA = 480;
    localparam int VF = 10;
    localparam int VS = 2;
    localparam int VB = 33;
    localparam int VT = 525;

    // Stored picture geometry and pixel format {R,G,B}
    localparam int PIC_H_DEF = 280;
    localparam int PIC_V_DEF = 210;
    localparam int PIX_W     = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } pf_state_t;

endpackage

// File: rtl/vga_sync_fifo.sv
// Show-ahead synchronous FIFO with flush; head_dat is the oldest entry, 0 when empty.
// Latency: a push is visible at the head the clock after it is written.
// Backpressure: none internally; callers must not push when full unless popping the same clock.
//
// Ports: clk, rst_n (async, active-low), flush (sync clear), push/push_dat, pop,
//        head_dat, count (entries held), empty, full.
module vga_sync_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 24,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    // A pop frees the slot this clock, so push-on-full with pop is safe.
    assign do_push  = push && (!full || do_pop);
    assign head_dat = empty ? '0 : store[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: contents are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push && !flush) store[wr_ptr] <= push_dat;
    end

    // Upstream credit accounting must make a lost push impossible.
    always @(posedge clk) begin
        if (rst_n && !flush) assert (!(push && full && !pop));
    end

endmodule

// File: rtl/vga_pixel_prefetch.sv
// Prefetches picture pixels from synchronous image memory into a show-ahead FIFO for the VGA stage.
// Latency: first read the clock after frame_start; FIFO full FIFO_DEPTH+MEM_LAT+1 clocks after it.
// Backpressure: reads issued only while fifo_count+inflight < FIFO_DEPTH; pop on empty flags underflow.
//
// Ports: clk25 pixel clock, KEY0 async active-low reset, frame_start restart pulse,
//        pix_req/pix_data/pix_valid/underflow to the VGA stage,
//        mem_addr/mem_rd/mem_q to the image memory.
module vga_pixel_prefetch
    import vga_pkg::*;
#(
    parameter int PIC_H      = PIC_H_DEF,
    parameter int PIC_V      = PIC_V_DEF,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = PIX_W,
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_LAT    = 1
) (
    input  logic              clk25,
    input  logic              KEY0,
    input  logic              frame_start,
    input  logic              pix_req,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              underflow,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIC_H * PIC_V - 1);

    pf_state_t         state;
    logic [ADDR_W-1:0] addr;
    logic              addr_done;
    logic [CNT_W-1:0]  inflight;
    logic [MEM_LAT-1:0] vld_sr;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W:0]    credit_used;
    logic              issue;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] issue_addr;

    always_comb begin
        credit_used = {1'b0, fifo_count} + {1'b0, inflight};
        // frame_start restarts at address 0 with an empty FIFO, so it always has credit.
        issue_addr  = frame_start ? '0 : addr;
        issue       = frame_start ||
                      ((state != ST_IDLE) && !addr_done &&
                       (credit_used < (CNT_W+1)'(FIFO_DEPTH)));
        push        = vld_sr[MEM_LAT-1] && !frame_start;
        pop         = pix_req && !fifo_empty && !frame_start;
    end

    always_ff @(posedge clk25 or negedge KEY0) begin
        if (!KEY0) begin
            state     <= ST_IDLE;
            addr      <= '0;
            addr_done <= 1'b0;
            inflight  <= '0;
            vld_sr    <= '0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            underflow <= 1'b0;
        end else begin
            mem_rd <= issue;
            if (issue) begin
                mem_addr <= issue_addr;
                // Hold on the last address; no wrap until the next frame_start.
                if (issue_addr == LAST_ADDR) begin
                    addr      <= issue_addr;
                    addr_done <= 1'b1;
                end else begin
                    addr      <= issue_addr + ADDR_W'(1);
                    addr_done <= 1'b0;
                end
            end

            // Clearing the tracker on frame_start discards data of reads already in flight.
            vld_sr[0] <= mem_rd && !frame_start;
            for (int i = 1; i < MEM_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1] && !frame_start;
            end

            if (frame_start) begin
                state     <= ST_FILL;
                inflight  <= CNT_W'(1);
                underflow <= 1'b0;
            end else begin
                inflight <= inflight + CNT_W'(issue) - CNT_W'(push);
                if (pix_req && fifo_empty) underflow <= 1'b1;
                case (state)
                    ST_FILL: if (fifo_full || addr_done) state <= ST_RUN;
                    default: ;
                endcase
            end
        end
    end

    vga_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk      (clk25),
        .rst_n    (KEY0),
        .flush    (frame_start),
        .push     (push),
        .push_dat (mem_q),
        .pop      (pop),
        .head_dat (pix_data),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign pix_valid = !fifo_empty;

endmodule

// File: tb/tb_vga_pixel_prefetch.sv
// Bench for vga_pixel_prefetch: full-size picture at MEM_LAT=1 plus a small picture at MEM_LAT=2.
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_pixel_prefetch;

    localparam int NPIX1 = 280 * 210;
    localparam int NPIX2 = 8 * 4;

    logic        clk25 = 1'b0;
    logic        KEY0;
    logic        fs1, req1, pv1, uf1, rd1;
    logic [23:0] pd1, mq1;
    logic [15:0] a1;
    logic        fs2, req2, pv2, uf2, rd2;
    logic [23:0] pd2, mq2, m2_s0;
    logic [15:0] a2;

    int total = 0;
    int bad   = 0;

    logic [23:0] q1[$];
    logic [23:0] q2[$];
    int exp_rd1 = 0, rd_cnt1 = 0, last_rd1 = 0;
    int exp_rd2 = 0, rd_cnt2 = 0, max_cnt2 = 0;

    always #20 clk25 = ~clk25;

    vga_pixel_prefetch u_dut (
        .clk25(clk25), .KEY0(KEY0), .frame_start(fs1), .pix_req(req1),
        .pix_data(pd1), .pix_valid(pv1), .underflow(uf1),
        .mem_addr(a1), .mem_rd(rd1), .mem_q(mq1)
    );

    vga_pixel_prefetch #(.PIC_H(8), .PIC_V(4), .ADDR_W(16), .DATA_W(24),
                         .FIFO_DEPTH(4), .MEM_LAT(2)) u_dut2 (
        .clk25(clk25), .KEY0(KEY0), .frame_start(fs2), .pix_req(req2),
        .pix_data(pd2), .pix_valid(pv2), .underflow(uf2),
        .mem_addr(a2), .mem_rd(rd2), .mem_q(mq2)
    );

    // Image memory models: q = {8'h00, addr}, MEM_LAT clocks after the address.
    always @(posedge clk25) begin
        mq1   <= {8'h00, a1};
        m2_s0 <= {8'h00, a2};
        mq2   <= m2_s0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboards: reads must walk addresses in order; popped pixels must match queue heads.
    always @(negedge clk25) begin
        if (KEY0 && !fs1) begin
            if (rd1) begin
                chk("rd_addr1", a1, exp_rd1);
                exp_rd1++;
                rd_cnt1++;
                last_rd1 = int'(a1);
            end
            if (req1 && pv1) begin
                chk("pix1_expected", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) chk("pix1", pd1, q1.pop_front());
            end
        end
        if (KEY0 && !fs2) begin
            if (int'(u_dut2.fifo_count) > max_cnt2) max_cnt2 = int'(u_dut2.fifo_count);
            if (rd2) begin
                chk("rd_addr2", a2, exp_rd2);
                exp_rd2++;
                rd_cnt2++;
            end
            if (req2 && pv2) begin
                chk("pix2_expected", 32'(q2.size() != 0), 1);
                if (q2.size() != 0) chk("pix2", pd2, q2.pop_front());
            end
        end
    end

    task automatic pulse_fs1();
        @(posedge clk25);
        #1;
        fs1 = 1'b1;
        q1.delete();
        for (int i = 0; i < NPIX1; i++) q1.push_back(24'(i));
        exp_rd1 = 0;
        rd_cnt1 = 0;
        @(posedge clk25);
        #1;
        fs1 = 1'b0;
    endtask

    task automatic pulse_fs2();
        @(posedge clk25);
        #1;
        fs2 = 1'b1;
        q2.delete();
        for (int i = 0; i < NPIX2; i++) q2.push_back(24'(i));
        exp_rd2 = 0;
        rd_cnt2 = 0;
        @(posedge clk25);
        #1;
        fs2 = 1'b0;
    endtask

    initial begin
        int snap;
        int sent;
        KEY0 = 1'b0; fs1 = 1'b0; req1 = 1'b0; fs2 = 1'b0; req2 = 1'b0;

        // Reset state
        repeat (2) @(negedge clk25);
        chk("rst_pix_valid", pv1, 0);
        chk("rst_pix_data", pd1, 0);
        chk("rst_underflow", uf1, 0);
        chk("rst_mem_rd", rd1, 0);
        chk("rst_mem_addr", a1, 0);
        @(posedge clk25);
        #1 KEY0 = 1'b1;
        repeat (5) @(posedge clk25);
        @(negedge clk25);
        chk("idle_no_reads", rd_cnt1, 0);

        // Fill with no demand: reads 0..3 only, full at clock 6
        pulse_fs1();
        @(negedge clk25);
        chk("first_rd", rd1, 1);
        chk("first_addr", a1, 0);
        repeat (4) @(posedge clk25);
        @(negedge clk25);
        chk("fill_cnt_clk5", u_dut.fifo_count, 3);
        @(posedge clk25);
        @(negedge clk25);
        chk("fill_cnt_clk6", u_dut.fifo_count, 4);
        repeat (10) @(posedge clk25);
        @(negedge clk25);
        chk("fill_reads", rd_cnt1, 4);
        chk("fill_valid", pv1, 1);
        chk("fill_head", pd1, 0);

        // Whole frame at one pixel per clock, then one request too many
        @(posedge clk25);
        #1 req1 = 1'b1;
        repeat (NPIX1) @(posedge clk25);
        @(negedge clk25);
        chk("end_valid", pv1, 0);
        chk("end_data", pd1, 0);
        chk("end_uf_before", uf1, 0);
        @(posedge clk25);
        #1 req1 = 1'b0;
        @(negedge clk25);
        chk("end_uf_set", uf1, 1);
        chk("end_queue_left", q1.size(), 0);
        chk("end_read_count", rd_cnt1, NPIX1);
        chk("end_last_addr", last_rd1, NPIX1 - 1);
        repeat (5) @(posedge clk25);
        @(negedge clk25);
        chk("end_no_more_reads", rd_cnt1, NPIX1);

        // Next frame clears underflow and restarts at address 0
        pulse_fs1();
        @(negedge clk25);
        chk("restart_uf_clr", uf1, 0);
        chk("restart_rd", rd1, 1);
        chk("restart_addr", a1, 0);

        // Mid-frame restart with pix_req high in the frame_start clock
        repeat (8) @(posedge clk25);
        #1 req1 = 1'b1;
        repeat (1001) @(posedge clk25);
        pulse_fs1();
        req1 = 1'b0;
        @(negedge clk25);
        chk("flush_empty", pv1, 0);
        repeat (8) @(posedge clk25);
        #1 req1 = 1'b1;
        repeat (20) @(posedge clk25);
        @(negedge clk25);
        chk("flush_no_uf", uf1, 0);

        // Asynchronous reset while running
        @(posedge clk25);
        #5 KEY0 = 1'b0;
        #1;
        chk("arst_valid", pv1, 0);
        chk("arst_data", pd1, 0);
        chk("arst_rd", rd1, 0);
        chk("arst_addr", a1, 0);
        chk("arst_uf", uf1, 0);
        req1 = 1'b0;
        repeat (2) @(posedge clk25);
        #1 KEY0 = 1'b1;
        snap = rd_cnt1;
        repeat (10) @(posedge clk25);
        @(negedge clk25);
        chk("arst_no_reads", rd_cnt1, snap);
        pulse_fs1();
        @(negedge clk25);
        chk("arst_restart_addr", a1, 0);
        repeat (8) @(posedge clk25);
        @(negedge clk25);
        chk("arst_refill_valid", pv1, 1);
        chk("arst_refill_head", pd1, 0);

        // Small picture, MEM_LAT=2, bursty demand: 3 clocks on, 2 off
        pulse_fs2();
        repeat (10) @(posedge clk25);
        #1;
        sent = 0;
        for (int cyc = 0; cyc < 300 && q2.size() != 0; cyc++) begin
            req2 = ((cyc % 5) < 3) && (sent < NPIX2);
            if (req2) sent++;
            @(posedge clk25);
            #1;
        end
        req2 = 1'b0;
        repeat (5) @(posedge clk25);
        @(negedge clk25);
        chk("burst_drained", q2.size(), 0);
        chk("burst_no_uf", uf2, 0);
        chk("burst_cnt_le_depth", 32'(max_cnt2 <= 4), 1);
        chk("burst_read_count", rd_cnt2, NPIX2);
        chk("burst_valid_end", pv2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
